// File: rtl/dtfm_serial_tx.sv
// DTFM serial link transmitter: frames 12-bit words MSB first onto dCLK/dFM/dDAT.
// Optional DTFM_TX_TESTPAT_EN adds test_mode, which swaps word_data for an internal counter.
module dtfm_serial_tx #(
    parameter int unsigned HALF_DIV      = 12,
    parameter int unsigned FRAME_BITS    = 10240,
    parameter int unsigned MARKER_PERIOD = 2816,
    parameter int unsigned SYNC_PERIODS  = 4,
    parameter int unsigned PAUSE_PERIODS = 8,
    parameter int unsigned GAP_PERIODS   = 16
) (
    input  logic        clk240,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] word_data,
    input  logic        word_valid,
`ifdef DTFM_TX_TESTPAT_EN
    input  logic        test_mode,
`endif
    output logic        word_ready,
    output logic        dCLK,
    output logic        dFM,
    output logic        dDAT,
    output logic        frame_start,
    output logic        underrun,
    output logic        busy
);

    localparam int unsigned Per    = 2 * HALF_DIV;
    localparam int unsigned PhW    = (Per > 1) ? $clog2(Per) : 1;
    localparam int unsigned MaxSP  = (SYNC_PERIODS > PAUSE_PERIODS) ? SYNC_PERIODS : PAUSE_PERIODS;
    localparam int unsigned MaxPer = (MaxSP > GAP_PERIODS) ? MaxSP : GAP_PERIODS;
    localparam int unsigned PcW    = $clog2(MaxPer + 1);
    localparam int unsigned MkW    = $clog2(MARKER_PERIOD + 1);

    localparam logic [PhW-1:0] PhLast    = PhW'(Per - 1);
    localparam logic [PhW-1:0] HalfPh    = PhW'(HALF_DIV);
    localparam logic [PcW-1:0] SyncLast  = PcW'(SYNC_PERIODS - 1);
    localparam logic [PcW-1:0] PauseLast = PcW'(PAUSE_PERIODS - 1);
    localparam logic [PcW-1:0] GapLast   = PcW'(GAP_PERIODS - 1);
    localparam logic [MkW-1:0] MkLast    = MkW'(MARKER_PERIOD - 1);
    localparam logic [13:0]    FrameBits = 14'(FRAME_BITS);

    typedef enum logic [2:0] {StIdle, StSync, StPause, StData, StGap} state_e;

    state_e           state_q, state_d;
    logic [PhW-1:0]   ph_q, ph_d, ph_nx;
    logic [PcW-1:0]   pc_q, pc_d;
    logic [13:0]      bit_q, bit_d, bit_inc;
    logic [MkW-1:0]   mk_q, mk_d;
    logic [3:0]       widx_q, widx_d;
    logic [11:0]      sh_q, sh_d, hold_q, hold_d, load_word, src;
    logic             hold_full_q, hold_full_d;
    logic             dclk_q, dclk_d, dfm_q, dfm_d, ddat_q, ddat_d;
    logic             fs_q, fs_d, ur_q, ur_d, busy_q, busy_d, rdy_q, rdy_d;
    logic             rise, load, xfer, use_hold, period_end;

`ifdef DTFM_TX_TESTPAT_EN
    logic             tm_q, tm_d;
    logic [11:0]      tcnt_q, tcnt_d;
    assign use_hold = ~tm_q;
`else
    assign use_hold = 1'b1;
`endif

    assign xfer = word_valid & rdy_q;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        pc_d        = pc_q;
        bit_d       = bit_q;
        mk_d        = mk_q;
        widx_d      = widx_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        dclk_d      = dclk_q;
        dfm_d       = dfm_q;
        ddat_d      = ddat_q;
        fs_d        = 1'b0;
        ur_d        = 1'b0;
        rise        = 1'b0;
        load        = 1'b0;
        src         = sh_q;
        load_word   = hold_full_q ? hold_q : 12'h000;
        ph_nx       = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
        period_end  = (ph_q == PhLast);
        bit_inc     = bit_q + 14'd1;
`ifdef DTFM_TX_TESTPAT_EN
        tm_d        = tm_q;
        tcnt_d      = tcnt_q;
        if (tm_q) load_word = tcnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                ph_d = '0;
                pc_d = '0;
`ifdef DTFM_TX_TESTPAT_EN
                tm_d = test_mode;
`endif
                if (en) begin
                    state_d = StSync;
                    dfm_d   = 1'b1;
                    fs_d    = 1'b1;
                    widx_d  = 4'd0;
                    bit_d   = '0;
                    mk_d    = '0;
                end
            end
            StSync: begin
                ph_d = ph_nx;
                if (period_end) begin
                    if (pc_q == SyncLast) begin
                        pc_d    = '0;
                        state_d = StPause;
                        dfm_d   = 1'b0;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            StPause: begin
                ph_d = ph_nx;
                if (period_end) begin
                    if (pc_q == PauseLast) begin
                        pc_d    = '0;
                        ph_d    = '0;
                        state_d = StData;
                        rise    = 1'b1;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            StData: begin
                ph_d = ph_nx;
                if (ph_nx == '0) rise = 1'b1;
                // Falling edge: the far end samples here, so bit accounting happens now.
                if (ph_nx == HalfPh) begin
                    dclk_d = 1'b0;
                    bit_d  = bit_inc;
                    mk_d   = (mk_q == MkLast) ? '0 : mk_q + 1'b1;
                    if (bit_inc == FrameBits) begin
                        state_d = StGap;
                        ph_d    = '0;
                        pc_d    = '0;
                    end else if (mk_q == MkLast) begin
                        state_d = StPause;
                        ph_d    = '0;
                        pc_d    = '0;
                    end
                end
            end
            StGap: begin
                bit_d = '0;
                mk_d  = '0;
                ph_d  = ph_nx;
                if (period_end) begin
                    if (pc_q == GapLast) begin
                        pc_d = '0;
                        ph_d = '0;
                        if (en) begin
                            state_d = StSync;
                            dfm_d   = 1'b1;
                            fs_d    = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (rise) begin
            dclk_d = 1'b1;
            if (widx_q == 4'd0) begin
                load = 1'b1;
                src  = load_word;
            end
            ddat_d = src[11];
            sh_d   = {src[10:0], 1'b0};
            widx_d = (widx_q == 4'd11) ? 4'd0 : widx_q + 4'd1;
        end

        if (load && use_hold) begin
            hold_full_d = 1'b0;
            ur_d        = ~hold_full_q;
        end
`ifdef DTFM_TX_TESTPAT_EN
        if (load && tm_q) tcnt_d = tcnt_q + 12'd1;
`endif
        // A transfer in the same cycle as a load refills the register just emptied.
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_d      = word_data;
        end

        rdy_d  = ~hold_full_d;
`ifdef DTFM_TX_TESTPAT_EN
        if (tm_d) rdy_d = 1'b0;
`endif
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk240 or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ph_q        <= '0;
            pc_q        <= '0;
            bit_q       <= '0;
            mk_q        <= '0;
            widx_q      <= 4'd0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            dclk_q      <= 1'b0;
            dfm_q       <= 1'b0;
            ddat_q      <= 1'b0;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
`ifdef DTFM_TX_TESTPAT_EN
            tm_q        <= 1'b0;
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            pc_q        <= pc_d;
            bit_q       <= bit_d;
            mk_q        <= mk_d;
            widx_q      <= widx_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            dclk_q      <= dclk_d;
            dfm_q       <= dfm_d;
            ddat_q      <= ddat_d;
            fs_q        <= fs_d;
            ur_q        <= ur_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
`ifdef DTFM_TX_TESTPAT_EN
            tm_q        <= tm_d;
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    assign word_ready  = rdy_q;
    assign dCLK        = dclk_q;
    assign dFM         = dfm_q;
    assign dDAT        = ddat_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dtfm_serial_tx.sv
// Bench for dtfm_serial_tx with a shortened frame (90 bits, markers every 30) to keep runs short;
// a word scoreboard checks every dCLK rise while the main thread checks framing and corner cases.
module tb_dtfm_serial_tx;

    localparam int HD = 12;
    localparam int FB = 90;
    localparam int MP = 30;

    logic        clk240 = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [11:0] word_data = 12'h000;
    logic        word_valid = 1'b0;
    logic        word_ready, dCLK, dFM, dDAT, frame_start, underrun, busy;

    always #2 clk240 = ~clk240;

    dtfm_serial_tx #(
        .HALF_DIV     (HD),
        .FRAME_BITS   (FB),
        .MARKER_PERIOD(MP),
        .SYNC_PERIODS (4),
        .PAUSE_PERIODS(8),
        .GAP_PERIODS  (16)
    ) dut (
        .clk240     (clk240),
        .rst        (rst),
        .en         (en),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .dCLK       (dCLK),
        .dFM        (dFM),
        .dDAT       (dDAT),
        .frame_start(frame_start),
        .underrun   (underrun),
        .busy       (busy)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    typedef struct {
        logic [11:0] data;
        logic [11:0] bits;  // expected dDAT sequence, first rise in bit 11
    } vec_t;

    vec_t        tbl [6];
    logic [11:0] exp_q [$];
    int          ti = 0;
    bit          drv_on = 1'b0;
    logic [11:0] drv_w, drv_e;

    // Producer: keeps the holding register topped up while enabled.
    initial begin
        forever begin
            @(negedge clk240);
            if (drv_on && rst && word_ready) begin
                if (ti < 6) begin
                    drv_w = tbl[ti].data;
                    drv_e = tbl[ti].bits;
                    ti++;
                end else begin
                    drv_w = 12'($urandom_range(0, 4095));
                    drv_e = drv_w;
                end
                word_data  = drv_w;
                word_valid = 1'b1;
                @(posedge clk240);
                #1;
                word_valid = 1'b0;
                exp_q.push_back(drv_e);
            end
        end
    end

    // Scoreboard: a word start with nothing queued must read as an underrun of zeros.
    int          idx = 0;
    int          falls_frame = 0;
    int          ur_seen = 0;
    logic        prev_clk = 1'b0, busy_prev = 1'b0, rise_dat = 1'b0, eur = 1'b0;
    logic [11:0] cur = 12'h000;

    initial begin
        forever begin
            @(negedge clk240);
            if (!rst) begin
                idx       = 0;
                prev_clk  = 1'b0;
                busy_prev = 1'b0;
            end else begin
                if (frame_start) begin
                    falls_frame = 0;
                    if (!busy_prev) idx = 0;
                end
                if (underrun) ur_seen++;
                if (dCLK && !prev_clk) begin
                    if (idx == 0) begin
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            eur = 1'b0;
                        end else begin
                            cur = 12'h000;
                            eur = 1'b1;
                        end
                    end
                    check("ddat_bit", int'(dDAT), int'(cur[11-idx]));
                    check("underrun_at_rise", int'(underrun), (idx == 0) ? int'(eur) : 0);
                    rise_dat = dDAT;
                    idx = (idx == 11) ? 0 : idx + 1;
                end
                if (!dCLK && prev_clk) begin
                    check("ddat_stable_at_fall", int'(dDAT), int'(rise_dat));
                    falls_frame++;
                end
                prev_clk  = dCLK;
                busy_prev = busy;
            end
        end
    end

    task automatic check_outputs(input string tag, input int rdy);
        check({tag, "_dclk"}, int'(dCLK), 0);
        check({tag, "_dfm"}, int'(dFM), 0);
        check({tag, "_ddat"}, int'(dDAT), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_word_ready"}, int'(word_ready), rdy);
    endtask

    task automatic wait_fs(input string name, input int lim);
        int n = 0;
        do begin
            @(negedge clk240);
            n++;
        end while (!frame_start && n < lim);
        check(name, int'(frame_start), 1);
    endtask

    task automatic wait_falls(input string name, input int target, input int lim);
        int n = 0;
        while (falls_frame < target && n < lim) begin
            @(negedge clk240);
            n++;
        end
        check(name, int'(falls_frame >= target), 1);
    endtask

    int n, hi, lo, fs_cnt, falls, since, ur0;
    bit clk_bad, dfm_bad, p;
    int seg_falls [$];
    int seg_low [$];

    initial begin
        tbl[0] = '{12'hA5C, 12'b1010_0101_1100};
        tbl[1] = '{12'hFFF, 12'b1111_1111_1111};
        tbl[2] = '{12'h000, 12'b0000_0000_0000};
        tbl[3] = '{12'h801, 12'b1000_0000_0001};
        tbl[4] = '{12'h3C6, 12'b0011_1100_0110};
        tbl[5] = '{12'h555, 12'b0101_0101_0101};

        repeat (5) @(negedge clk240);
        check_outputs("in_reset", 0);
        rst = 1'b1;
        repeat (1000) @(negedge clk240);
        check_outputs("idle", 1);

        // First frame: table words, exact sync/pause/bit timing.
        drv_on = 1'b1;
        repeat (4) @(negedge clk240);
        check("ready_after_fill", int'(word_ready), 0);
        en = 1'b1;
        n = 0;
        while (!frame_start && n < 10) begin
            @(negedge clk240);
            n++;
        end
        check("sync_latency", n, 1);
        check("dfm_at_frame_start", int'(dFM), 1);
        hi = 0; fs_cnt = 0; clk_bad = 1'b0;
        while (dFM && hi < 1000) begin
            fs_cnt += int'(frame_start);
            if (dCLK) clk_bad = 1'b1;
            @(negedge clk240);
            hi++;
        end
        check("dfm_high_cycles", hi, 4 * 2 * HD);
        check("frame_start_pulses", fs_cnt, 1);
        check("dclk_low_in_sync", int'(clk_bad), 0);
        lo = 0;
        while (!dCLK && lo < 1000) begin
            @(negedge clk240);
            lo++;
        end
        check("pause_after_sync", lo, 8 * 2 * HD);
        hi = 0;
        while (dCLK && hi < 100) begin
            @(negedge clk240);
            hi++;
        end
        check("dclk_high_cycles", hi, HD);

        // Segment structure up to the next frame's dFM rise.
        falls = 1; since = 0; p = 1'b0; n = 0;
        while (!frame_start && n < 6000) begin
            @(negedge clk240);
            n++;
            since++;
            if (dCLK && !p && since != HD) begin
                seg_falls.push_back(falls);
                seg_low.push_back(since);
                falls = 0;
            end
            if (!dCLK && p) begin
                falls++;
                since = 0;
            end
            p = dCLK;
        end
        seg_falls.push_back(falls);
        seg_low.push_back(since);
        check("frame2_start", int'(frame_start), 1);
        check("segment_count", seg_falls.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("seg%0d_falls", k), (seg_falls.size() > k) ? seg_falls[k] : -1, MP);
            check($sformatf("seg%0d_low", k), (seg_low.size() > k) ? seg_low[k] : -1,
                  (k < 2) ? 8 * 2 * HD : 16 * 2 * HD);
        end

        // Starve the link: frame 3 spans bits 180..269, i.e. 8 word starts.
        drv_on = 1'b0;
        wait_fs("frame3_start", 6000);
        ur0 = ur_seen;
        wait_fs("frame4_start", 6000);
        check("underruns_in_frame3", ur_seen - ur0, 8);

        // Drop en mid-frame: frame still completes, then gap, then idle.
        wait_falls("reach_bit40", 40, 3000);
        en = 1'b0;
        n = 0; since = 0; p = dCLK; dfm_bad = 1'b0;
        while (busy && n < 6000) begin
            @(negedge clk240);
            n++;
            since++;
            if (!dCLK && p) since = 0;
            if (dFM || frame_start) dfm_bad = 1'b1;
            p = dCLK;
        end
        check("busy_falls", int'(busy), 0);
        check("bits_after_en_low", falls_frame, FB);
        check("gap_to_idle", since, 16 * 2 * HD);
        repeat (500) begin
            @(negedge clk240);
            if (dFM || busy) dfm_bad = 1'b1;
        end
        check("no_sync_after_en_low", int'(dfm_bad), 0);

        // Reset mid-frame, then a fresh frame must start with the new word.
        ti = 0;
        drv_on = 1'b1;
        repeat (4) @(negedge clk240);
        en = 1'b1;
        wait_fs("frame5_start", 100);
        wait_falls("reach_bit40_again", 40, 3000);
        rst = 1'b0;
        #1;
        check_outputs("async_reset", 0);
        drv_on = 1'b0;
        repeat (3) @(negedge clk240);
        exp_q.delete();
        ti = 0;
        rst = 1'b1;
        drv_on = 1'b1;
        wait_fs("fresh_sync", 100);
        check("fresh_sync_dfm", int'(dFM), 1);
        wait_falls("post_reset_bits", 24, 3000);
        en = 1'b0;
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clk240);
            n++;
        end
        check("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
